// File: rtl/kmap_pkg.sv
// kmap_pkg: shared types, default truth table and sweep ordering for the K-map sweep checker.
package kmap_pkg;
    localparam logic [7:0] KMAP_EXPECTED_F = 8'h96;
    typedef enum logic [1:0] {IDLE, SWEEP, DONE} kmap_sweep_state_t;
    function automatic logic [2:0] kmap_order(logic [2:0] step, logic gray);
        return gray ? (step ^ (step >> 1)) : step;
    endfunction
endpackage

// File: rtl/kmap_sweep_checker.sv
// kmap_sweep_checker: sweeps {A,B,C} into a K-map block and checks F; KMAP_SWEEP_GRAY_ORDER_EN selects Gray order.
module kmap_sweep_checker
    import kmap_pkg::*;
#(
    parameter logic [7:0] EXPECTED      = KMAP_EXPECTED_F,
    parameter int         SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] abc_o,
    input  logic       f_i,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_o,
    output logic       pass,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_bad,
    output logic       first_bad_vld
);
`ifdef KMAP_SWEEP_GRAY_ORDER_EN
    localparam logic GRAY = 1'b1;
`else
    localparam logic GRAY = 1'b0;
`endif
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    kmap_sweep_state_t r_state, w_next;
    logic [2:0] r_step, r_abc, r_first_bad;
    logic [3:0] r_settle, r_cnt;
    logic [7:0] r_table, w_table;
    logic       r_pass, r_fbv, w_sample;
    assign w_sample = (r_state == SWEEP) && (r_settle == 4'd0);
    // Table including the bit being sampled now, so pass/count are valid during done
    always_comb begin
        w_table        = r_table;
        w_table[r_abc] = f_i;
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE  ? (start ? SWEEP : IDLE) :
                 r_state == SWEEP ? ((w_sample && r_step == 3'd7) ? DONE : SWEEP) : IDLE;
    end
    always_comb begin
        busy = r_state == SWEEP;
        done = r_state == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step      <= '0;
            r_abc       <= '0;
            r_settle    <= '0;
            r_table     <= '0;
            r_pass      <= 1'b0;
            r_cnt       <= '0;
            r_first_bad <= '0;
            r_fbv       <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_step      <= '0;
            r_abc       <= kmap_order(3'd0, GRAY);
            r_settle    <= SETTLE_LOAD;
            r_table     <= '0;
            r_pass      <= 1'b0;
            r_cnt       <= '0;
            r_first_bad <= '0;
            r_fbv       <= 1'b0;
        end else if (r_state == SWEEP) begin
            if (!w_sample) begin
                r_settle <= r_settle - 4'd1;
            end else begin
                r_table <= w_table;
                if (f_i != EXPECTED[r_abc] && !r_fbv) begin
                    r_first_bad <= r_abc;
                    r_fbv       <= 1'b1;
                end
                if (r_step == 3'd7) begin
                    r_pass <= w_table == EXPECTED;
                    r_cnt  <= 4'($countones(w_table ^ EXPECTED));
                end else begin
                    r_step   <= r_step + 3'd1;
                    r_abc    <= kmap_order(r_step + 3'd1, GRAY);
                    r_settle <= SETTLE_LOAD;
                end
            end
        end
    end
    assign abc_o         = r_abc;
    assign table_o       = r_table;
    assign pass          = r_pass;
    assign mismatch_cnt  = r_cnt;
    assign first_bad     = r_first_bad;
    assign first_bad_vld = r_fbv;
endmodule

// File: tb/tb_kmap_sweep_checker.sv
// tb_kmap_sweep_checker: directed checks of kmap_sweep_checker with SETTLE_CYCLES of 1 and 3.
module tb_kmap_sweep_checker;
    import kmap_pkg::*;
`ifdef KMAP_SWEEP_GRAY_ORDER_EN
    localparam logic GRAY = 1'b1;
`else
    localparam logic GRAY = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset = 1'b1, start1 = 1'b0, start3 = 1'b0, glitch3 = 1'b0;
    logic [1:0] mode1 = 2'd0;
    logic [7:0] golden = 8'h96;
    logic [2:0] gray_seq [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    logic [2:0] abc1, abc3, fb1, fb3;
    logic       f1, f3, busy1, busy3, done1, done3, pass1, pass3, fbv1, fbv3;
    logic [7:0] tbl1, tbl3;
    logic [3:0] cnt1, cnt3;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    // Stand-in K-map block: 0 = correct, 1 = stuck at 0, 2 = inverted only at abc 010
    assign f1 = (mode1 == 2'd1) ? 1'b0 : (golden[abc1] ^ (mode1 == 2'd2 && abc1 == 3'd2));
    assign f3 = golden[abc3] ^ glitch3;
    kmap_sweep_checker #(.EXPECTED(8'h96), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .abc_o(abc1), .f_i(f1),
        .busy(busy1), .done(done1), .table_o(tbl1), .pass(pass1),
        .mismatch_cnt(cnt1), .first_bad(fb1), .first_bad_vld(fbv1)
    );
    kmap_sweep_checker #(.EXPECTED(8'h96), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abc_o(abc3), .f_i(f3),
        .busy(busy3), .done(done3), .table_o(tbl3), .pass(pass3),
        .mismatch_cnt(cnt3), .first_bad(fb3), .first_bad_vld(fbv3)
    );
    function automatic logic [2:0] ord(int k);
        return GRAY ? gray_seq[k] : 3'(k);
    endfunction
    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic run1(string nm, logic [7:0] tbl, logic [3:0] cnt, logic [2:0] fb, logic fbv, logic ps);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check({nm, " abc"}, abc1, ord(k));
            check({nm, " busy"}, busy1, 1);
            check({nm, " early_done"}, done1, 0);
            tick;
        end
        check({nm, " done"}, done1, 1);
        check({nm, " busy_at_done"}, busy1, 0);
        check({nm, " table"}, tbl1, tbl);
        check({nm, " pass"}, pass1, ps);
        check({nm, " cnt"}, cnt1, cnt);
        check({nm, " fbv"}, fbv1, fbv);
        if (fbv) check({nm, " first_bad"}, fb1, fb);
        tick;
        check({nm, " done_pulse"}, done1, 0);
        check({nm, " table_hold"}, tbl1, tbl);
        check({nm, " pass_hold"}, pass1, ps);
    endtask
    initial begin
        tick;
        tick;
        check("rst busy", busy1, 0);
        check("rst done", done1, 0);
        check("rst abc", abc1, 0);
        check("rst table", tbl1, 0);
        check("rst pass", pass1, 0);
        check("rst cnt", cnt1, 0);
        check("rst fbv", fbv1, 0);
        check("rst busy3", busy3, 0);
        reset = 1'b0;
        tick;
        check("idle busy", busy1, 0);
        run1("good", 8'h96, 4'd0, 3'd0, 1'b0, 1'b1);
        mode1 = 2'd1;
        run1("stuck0", 8'h00, 4'd4, 3'd1, 1'b1, 1'b0);
        mode1 = 2'd2;
        run1("inv2", 8'h92, 4'd1, 3'd2, 1'b1, 1'b0);
        mode1 = 2'd0;
        // Three-cycle hold: F glitches on the first two hold cycles, clean on the sampled one
        start3 = 1'b1;
        tick;
        start3 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            glitch3 = (c % 3) != 2;
            check("s3 abc", abc3, ord(c / 3));
            check("s3 busy", busy3, 1);
            check("s3 early_done", done3, 0);
            tick;
        end
        glitch3 = 1'b0;
        check("s3 done", done3, 1);
        check("s3 table", tbl3, 8'h96);
        check("s3 pass", pass3, 1);
        check("s3 cnt", cnt3, 0);
        check("s3 fbv", fbv3, 0);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        check("abort abc", abc1, ord(4));
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort busy", busy1, 0);
        check("abort done", done1, 0);
        check("abort abc0", abc1, 0);
        check("abort table", tbl1, 0);
        check("abort pass", pass1, 0);
        check("abort cnt", cnt1, 0);
        check("abort fbv", fbv1, 0);
        check("abort fb", fb1, 0);
        tick;
        check("abort no_done", done1, 0);
        check("abort idle", busy1, 0);
        run1("after_abort", 8'h96, 4'd0, 3'd0, 1'b0, 1'b1);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) tick;
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        check("ign abc", abc1, ord(4));
        for (int k = 0; k < 4; k++) tick;
        check("ign done", done1, 1);
        tick;
        check("ign idle", busy1, 0);
        tick;
        check("ign not_queued", busy1, 0);
        start1 = 1'b1;
        tick;
        check("held busy", busy1, 1);
        for (int k = 0; k < 8; k++) tick;
        check("held done", done1, 1);
        tick;
        check("held gap_busy", busy1, 0);
        check("held gap_done", done1, 0);
        tick;
        check("held restart", busy1, 1);
        check("held abc0", abc1, ord(0));
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) tick;
        check("held done2", done1, 1);
        check("held table", tbl1, 8'h96);
        tick;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
